// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registers a one-hot grant, holds it for a burst
// until last/beat-limit, then rotates priority and re-arbitrates without a bubble.
module rr_grant_ctrl #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] last,
    input  logic             ack,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [WIDTH-1:0] base,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             forced
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic             last_hit, limit_hit, burst_end, load;
    logic [WIDTH-1:0] base_next, pick;
    logic [WIDTH-1:0] grant_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic             grant_valid_d, forced_d;
    logic [CNT_W-1:0] beat_cnt_d;

    // Circular search starting at the one-hot base bit: scan two laps so the
    // wrap-around case needs no separate masking logic.
    function automatic logic [WIDTH-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        logic             started, found;
        g       = '0;
        started = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (b[k % WIDTH]) started = 1'b1;
            if (started && !found && r[k % WIDTH]) begin
                g[k % WIDTH] = 1'b1;
                found        = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] g);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (g[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // grant is one-hot, so masking last with it selects last[grant_idx].
    assign last_hit  = |(last & grant);
    assign limit_hit = (MAX_BURST != 0) && (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign burst_end = (state == BUSY) && ack && (last_hit || limit_hit);
    assign load      = (state == IDLE) || burst_end;
    assign base_next = burst_end ? {grant[WIDTH-2:0], grant[WIDTH-1]} : base;
    assign pick      = rr_pick(req, base_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= WIDTH'(1);
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            beat_cnt    <= '0;
            forced      <= 1'b0;
        end else begin
            state       <= state_next;
            base        <= base_next;
            grant       <= grant_d;
            grant_valid <= grant_valid_d;
            grant_idx   <= grant_idx_d;
            beat_cnt    <= beat_cnt_d;
            forced      <= forced_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (|req) state_next = BUSY;
            BUSY: if (burst_end && !(|pick)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant;
        grant_valid_d = grant_valid;
        grant_idx_d   = grant_idx;
        beat_cnt_d    = beat_cnt;
        forced_d      = burst_end && !last_hit;
        if (load) begin
            grant_d       = pick;
            grant_valid_d = |pick;
            grant_idx_d   = encode(pick);
            beat_cnt_d    = '0;
        end else if (ack) begin
            beat_cnt_d = beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (WIDTH=4, MAX_BURST=4) with hand-computed
// expected grant/base/beat_cnt/forced values.
module tb_rr_grant_ctrl;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] req, last;
    logic             ack;
    logic [WIDTH-1:0] grant, base;
    logic             grant_valid, forced;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    rr_grant_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_BURST(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .ack(ack),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .base(base), .beat_cnt(beat_cnt), .forced(forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic [3:0] b);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
        chk({tag, ".idx"},   32'(grant_idx), 32'(idx));
        chk({tag, ".base"},  32'(base), 32'(b));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        ack   = 1'b0;
        step();
        step();
        chk_grant("rst0", 4'b0000, 2'd0, 4'b0001);
        chk("rst0.cnt", 32'(beat_cnt), 0);
        chk("rst0.forced", 32'(forced), 0);
        rst_n = 1'b1;

        // Round robin with single-beat bursts
        req  = 4'b0101;
        ack  = 1'b1;
        last = 4'b1111;
        step(); chk_grant("rr1", 4'b0001, 2'd0, 4'b0001);
        step(); chk_grant("rr2", 4'b0100, 2'd2, 4'b0010);
        step(); chk_grant("rr3", 4'b0001, 2'd0, 4'b1000);
        step(); chk_grant("rr4", 4'b0100, 2'd2, 4'b0010);

        // Wrap-around
        req = 4'b1001;
        step(); chk_grant("wrap1", 4'b1000, 2'd3, 4'b1000);
        step(); chk_grant("wrap2", 4'b0001, 2'd0, 4'b0001);
        req = 4'b0000;
        step(); chk_grant("toidle", 4'b0000, 2'd0, 4'b0010);

        // ack while idle changes nothing
        step(); chk_grant("idleack", 4'b0000, 2'd0, 4'b0010);
        chk("idleack.cnt", 32'(beat_cnt), 0);
        chk("idleack.forced", 32'(forced), 0);

        // Asynchronous reset mid-burst
        req  = 4'b0100;
        ack  = 1'b0;
        last = 4'b0000;
        step(); chk_grant("pre_rst", 4'b0100, 2'd2, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk_grant("async_rst", 4'b0000, 2'd0, 4'b0001);
        chk("async_rst.cnt", 32'(beat_cnt), 0);
        chk("async_rst.forced", 32'(forced), 0);
        rst_n = 1'b1;
        req   = 4'b0000;
        step(); chk_grant("post_rst", 4'b0000, 2'd0, 4'b0001);

        // Burst lock, last on the 3rd beat, req[0] dropped mid-burst
        req = 4'b0011;
        ack = 1'b1;
        step(); chk_grant("lock1", 4'b0001, 2'd0, 4'b0001);
        chk("lock1.cnt", 32'(beat_cnt), 0);
        step(); chk_grant("lock2", 4'b0001, 2'd0, 4'b0001);
        chk("lock2.cnt", 32'(beat_cnt), 1);
        req = 4'b0010;
        step(); chk_grant("lock3", 4'b0001, 2'd0, 4'b0001);
        chk("lock3.cnt", 32'(beat_cnt), 2);
        last = 4'b0001;
        step(); chk_grant("lock_next", 4'b0010, 2'd1, 4'b0010);
        chk("lock_next.cnt", 32'(beat_cnt), 0);
        chk("lock_next.forced", 32'(forced), 0);
        last = 4'b0010;
        req  = 4'b0000;
        step(); chk_grant("lock_idle", 4'b0000, 2'd0, 4'b0100);

        // Forced release after 4 beats, sole requester regranted on the same edge
        req  = 4'b0100;
        last = 4'b0000;
        step(); chk_grant("frc0", 4'b0100, 2'd2, 4'b0100);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("frc.cnt", 32'(beat_cnt), 32'(i));
            chk("frc.nopulse", 32'(forced), 0);
        end
        step(); chk_grant("frc_end", 4'b0100, 2'd2, 4'b1000);
        chk("frc_end.forced", 32'(forced), 1);
        chk("frc_end.cnt", 32'(beat_cnt), 0);
        step();
        chk("frc_after.forced", 32'(forced), 0);
        chk("frc_after.cnt", 32'(beat_cnt), 1);

        // Stalled ack holds everything
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_grant("stall", 4'b0100, 2'd2, 4'b1000);
            chk("stall.cnt", 32'(beat_cnt), 1);
            chk("stall.forced", 32'(forced), 0);
        end
        ack = 1'b1;
        step();
        chk("resume.cnt", 32'(beat_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
